instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the main opcode decoder in the single-cycle MIPS CPU.
//  - Owns the PC register and drives the instruction-memory address.
//  - Presents the fetched word and its opcode field (instr[31:26]) to the decoder.
//  - Selects next PC (sequential / branch / jump) from the decoder's Branch, BranchType, Jump and the ALU zero flag.
//  - Adds a run/halt state machine, stall hold and retired-instruction counter.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  HALT_WORD  32'hFFFF_FFFF  instruction word that halts fetch
//  CNT_W      16             width of retired-instruction counter
// PORTS
//  clk_i          in   1      clock; all state updates on rising edge
//  rst_i          in   1      asynchronous, active-low reset
//  stall_i        in   1      1 = hold PC/state this cycle
//  imem_data_i    in   32     instruction word at imem_addr_o (combinational memory read)
//  branch_i       in   1      decoder Branch (beq/bne)
//  branch_type_i  in   1      0 = beq (taken if zero_i=1); 1 = bne (taken if zero_i=0)
//  jump_i         in   1      decoder Jump (j)
//  zero_i         in   1      ALU zero flag for current instruction
//  imem_addr_o    out  32     = pc_o
//  pc_o           out  32     current PC
//  pc_plus4_o     out  32     pc_o + 4 (mod 2^32)
//  instr_o        out  32     imem_data_i when valid_o=1, else 32'h0 (NOP)
//  op_o           out  6      instr_o[31:26]; drives decoder opcode input
//  valid_o        out  1      1 only in RUN and not halting word
//  halted_o       out  1      1 in HALT state
//  retired_o      out  CNT_W  count of instructions committed, saturating
// BEHAVIOUR
//  Reset (rst_i=0, asynchronous)
//   - pc=RESET_PC, state=IDLE, retired=0.
//   - Outputs: valid_o=0, halted_o=0, instr_o=0, op_o=0.
//   - Reset asserted mid-operation aborts immediately; no partial update survives.
//  FSM states: IDLE, RUN, HALT
//   - IDLE -> RUN : first clock edge after reset release; pc unchanged, valid_o=0.
//   - RUN  -> HALT: on edge where stall_i=0 and imem_data_i==HALT_WORD.
//     - pc is frozen and retired_o is not incremented.
//   - HALT: terminal until reset; valid_o=0, pc frozen, all inputs ignored.
//  RUN, stall_i=1: pc, retired, state unchanged; valid_o remains 1 (combinational view of the word).
//  RUN, stall_i=0, word != HALT_WORD: pc <= next_pc; retired <= retired+1, saturating at all-ones.
//  next_pc priority
//   1. jump_i=1: {pc_plus4[31:28], instr[25:0], 2'b00}
//   2. branch_i=1 and taken: pc_plus4 + (sign_ext(instr[15:0]) << 2)
//   3. otherwise: pc_plus4
//   - Jump and branch together: jump wins.
//   - Branch not taken: pc_plus4.
//  Arithmetic: all 32-bit, modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0. Low 2 PC bits always 0.
//  Control inputs are sampled only when valid_o=1 and stall_i=0; ignored in IDLE/HALT.
//  Latency: pc_o..op_o are combinational from pc reg + imem_data_i; one instruction per cycle.
// TESTING
//  1. Reset release, words at 0/4/8 = addi
//     -> cycle0 IDLE valid=0; then pc 0,4,8; retired 1,2,3.
//  2. pc=0x10, beq imm=16'h0003, branch=1, type=0, zero=1
//     -> next pc=0x20; same with zero=0 -> 0x14.
//  3. pc=0x10, bne imm=16'hFFFE, type=1, zero=0
//     -> next pc=0x0C; with zero=1 -> 0x14.
//  4. pc=0x4000_0000, j target 26'h0000100, jump=1 and branch=1
//     -> next pc=0x4000_0400.
//  5. stall_i=1 for 3 cycles at pc=0x8
//     -> pc stays 0x8, retired unchanged; resumes to 0xC.
//  6. HALT_WORD at 0x14 -> halted_o=1, pc stays 0x14, retired frozen.
//     Mid-run rst_i=0 -> pc=0, retired=0 immediately, no clock needed.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage: PC register, next-PC select, run/halt FSM, retired counter
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic [31:0]      imem_data_i,
    input  logic             branch_i,
    input  logic             branch_type_i,
    input  logic             jump_i,
    input  logic             zero_i,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic [31:0]      instr_o,
    output logic [5:0]       op_o,
    output logic             valid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [CNT_W-1:0] retired;
    logic             halted;

    logic             is_halt_word;
    logic             taken;
    logic [31:0]      pc_plus4;
    logic [31:0]      branch_off;
    logic [31:0]      next_pc;

    assign is_halt_word = (imem_data_i == HALT_WORD);
    assign pc_plus4     = pc + 32'd4;

    assign valid_o      = (state == S_RUN) && !is_halt_word;
    assign instr_o      = valid_o ? imem_data_i : 32'h0;
    assign op_o         = instr_o[31:26];
    assign pc_o         = pc;
    assign imem_addr_o  = pc;
    assign pc_plus4_o   = pc_plus4;
    assign halted_o     = halted;
    assign retired_o    = retired;

    // beq takes on zero, bne on non-zero; jump overrides any branch.
    assign taken      = branch_i && (branch_type_i ? !zero_i : zero_i);
    assign branch_off = {{14{instr_o[15]}}, instr_o[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump_i) begin
            next_pc = {pc_plus4[31:28], instr_o[25:0], 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            pc      <= {RESET_PC[31:2], 2'b00};
            retired <= '0;
            halted  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (!stall_i) begin
                        if (is_halt_word) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= next_pc;
                            if (retired != {CNT_W{1'b1}}) begin
                                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [31:0] ADDI  = 32'h2008_0001;
    localparam logic [31:0] BEQ3  = 32'h1109_0003;
    localparam logic [31:0] BNEM2 = 32'h1509_FFFE;
    localparam logic [31:0] J10   = 32'h0800_0004;
    localparam logic [31:0] JFAR  = 32'h0800_0100;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] ret;
        logic [31:0] word;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance: default parameters.
    logic        rst1 = 1'b0, stall1 = 1'b0, br1 = 1'b0, bt1 = 1'b0, jp1 = 1'b0, z1 = 1'b0;
    logic [31:0] word1 = ADDI;
    logic [31:0] addr1, pc1, pc4_1, instr1;
    logic [5:0]  op1;
    logic        valid1, halted1;
    logic [15:0] ret1;

    // Second instance: high reset PC and a 2-bit counter to reach saturation quickly.
    logic        rst2 = 1'b0, stall2 = 1'b0, br2 = 1'b0, bt2 = 1'b0, jp2 = 1'b0, z2 = 1'b0;
    logic [31:0] word2 = ADDI;
    logic [31:0] addr2, pc2, pc4_2, instr2;
    logic [5:0]  op2;
    logic        valid2, halted2;
    logic [1:0]  ret2;

    instr_fetch_unit u_dut (
        .clk_i(clk), .rst_i(rst1), .stall_i(stall1), .imem_data_i(word1),
        .branch_i(br1), .branch_type_i(bt1), .jump_i(jp1), .zero_i(z1),
        .imem_addr_o(addr1), .pc_o(pc1), .pc_plus4_o(pc4_1), .instr_o(instr1),
        .op_o(op1), .valid_o(valid1), .halted_o(halted1), .retired_o(ret1)
    );

    instr_fetch_unit #(.RESET_PC(32'h4000_0000), .CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst2), .stall_i(stall2), .imem_data_i(word2),
        .branch_i(br2), .branch_type_i(bt2), .jump_i(jp2), .zero_i(z2),
        .imem_addr_o(addr2), .pc_o(pc2), .pc_plus4_o(pc4_2), .instr_o(instr2),
        .op_o(op2), .valid_o(valid2), .halted_o(halted2), .retired_o(ret2)
    );

    exp_t q1[$];
    exp_t q2[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (valid1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check("dut1_pc", {32'h0, pc1}, {32'h0, e.pc});
                check("dut1_addr_pc4", {addr1, pc4_1}, {e.pc, e.pc + 32'd4});
                check("dut1_retired", {48'h0, ret1}, {48'h0, e.ret});
                check("dut1_instr_op", {26'h0, op1, instr1}, {26'h0, e.word[31:26], e.word});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid2) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = q2.pop_front();
                check("dut2_pc", {32'h0, pc2}, {32'h0, e.pc});
                check("dut2_retired", {62'h0, ret2}, {48'h0, e.ret});
                check("dut2_instr_op", {26'h0, op2, instr2}, {26'h0, e.word[31:26], e.word});
            end
        end
    end

    task automatic step1(input logic [31:0] w, input logic b, input logic t, input logic j,
                         input logic z, input logic s, input logic [31:0] epc, input int eret);
        @(posedge clk); #1;
        word1 = w; br1 = b; bt1 = t; jp1 = j; z1 = z; stall1 = s;
        q1.push_back('{epc, eret[15:0], w});
    endtask

    task automatic step2(input logic [31:0] w, input logic b, input logic t, input logic j,
                         input logic z, input logic [31:0] epc, input int eret);
        @(posedge clk); #1;
        word2 = w; br2 = b; bt2 = t; jp2 = j; z2 = z; stall2 = 1'b0;
        q2.push_back('{epc, eret[15:0], w});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", {32'h0, pc1}, 64'h0);
        check("reset_flags", {61'h0, valid1, halted1, |ret1}, 64'h0);
        check("reset_instr_op", {26'h0, op1, instr1}, 64'h0);
        rst1 = 1'b1;
        #1 check("idle_valid", {63'h0, valid1}, 64'h0);

        step1(ADDI,  0, 0, 0, 0, 0, 32'h00, 0);
        step1(ADDI,  0, 0, 0, 0, 0, 32'h04, 1);
        step1(ADDI,  0, 0, 0, 0, 1, 32'h08, 2);
        step1(ADDI,  0, 0, 0, 0, 1, 32'h08, 2);
        step1(ADDI,  0, 0, 0, 0, 1, 32'h08, 2);
        step1(ADDI,  0, 0, 0, 0, 0, 32'h08, 2);
        step1(ADDI,  0, 0, 0, 0, 0, 32'h0C, 3);
        step1(BEQ3,  1, 0, 0, 1, 0, 32'h10, 4);
        step1(J10,   0, 0, 1, 0, 0, 32'h20, 5);
        step1(BEQ3,  1, 0, 0, 0, 0, 32'h10, 6);
        step1(J10,   0, 0, 1, 0, 0, 32'h14, 7);
        step1(BNEM2, 1, 1, 0, 0, 0, 32'h10, 8);
        step1(J10,   0, 0, 1, 0, 0, 32'h0C, 9);
        step1(BNEM2, 1, 1, 0, 1, 0, 32'h10, 10);

        @(posedge clk); #1;
        word1 = HALTW; br1 = 0; bt1 = 0; jp1 = 0; z1 = 0; stall1 = 0;
        #1;
        check("halt_word_valid", {63'h0, valid1}, 64'h0);
        check("halt_word_instr_op", {26'h0, op1, instr1}, 64'h0);
        check("halt_word_pc", {32'h0, pc1}, 64'h14);
        @(posedge clk); #1;
        check("halted_state", {62'h0, halted1, valid1}, 64'h2);
        check("halted_pc_ret", {pc1, 16'h0, ret1}, {32'h14, 32'd11});
        word1 = J10; jp1 = 1; br1 = 1; z1 = 1;
        repeat (3) @(posedge clk);
        #1;
        check("halt_hold_pc_ret", {pc1, 16'h0, ret1}, {32'h14, 32'd11});
        check("halt_hold_flags", {62'h0, halted1, valid1}, 64'h2);

        rst1 = 1'b0;
        #1;
        check("async_reset_from_halt", {pc1, 15'h0, halted1, ret1}, 64'h0);
        @(posedge clk); #1;
        rst1 = 1'b1; word1 = ADDI; jp1 = 0; br1 = 0; z1 = 0;
        step1(ADDI, 0, 0, 0, 0, 0, 32'h00, 0);
        step1(ADDI, 0, 0, 0, 0, 0, 32'h04, 1);
        @(posedge clk); #1;
        check("pre_reset_pc", {32'h0, pc1}, 64'h08);
        rst1 = 1'b0;
        #1;
        check("async_reset_mid_run", {pc1, 15'h0, valid1, ret1}, 64'h0);

        @(posedge clk); #1;
        rst2 = 1'b1;
        #1 check("dut2_idle", {pc2, 31'h0, valid2}, {32'h4000_0000, 32'h0});
        step2(JFAR, 1, 0, 1, 1, 32'h4000_0000, 0);
        step2(ADDI, 0, 0, 0, 0, 32'h4000_0400, 1);
        step2(ADDI, 0, 0, 0, 0, 32'h4000_0404, 2);
        step2(ADDI, 0, 0, 0, 0, 32'h4000_0408, 3);
        step2(ADDI, 0, 0, 0, 0, 32'h4000_040C, 3);
        @(posedge clk); #1;
        rst2 = 1'b0;
        check("dut2_saturated", {pc2, 30'h0, ret2}, {32'h4000_0410, 32'd3});

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", {32'h0, 32'(q1.size() + q2.size())}, 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
